// File: rtl/lap_controller.sv
// lap_controller
//   Lap/split capture beside the stopwatch FSM and mm:ss counter. A lap pulse
//   while running stores the current time (or the delta since the previous
//   lap) in a small FIFO. The FIFO is drained one entry per rd_req, and the
//   popped entry appears on rd_* with rd_valid one cycle later.
//
//   Build option: define LAP_DELTA_EN to store lap deltas instead of
//   absolute split times.
//
//   Ports:
//     clk, rst_n       clock, synchronous active-low reset
//     status[1:0]      stopwatch state: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 IDLE
//     lap              single-cycle lap pulse
//     cur_min/cur_sec  running time from the time counter
//     rd_req           pop the oldest entry
//     rd_valid         rd_min/rd_sec/rd_idx valid this cycle
//     rd_idx           1-based lap number of the popped entry (wraps)
//     lap_count        entries buffered; full/empty derived from it
//     overflow         sticky: a lap was dropped because the buffer was full
//
//   mode     | meaning
//   ---------+-----------------------------------------------------------
//   CLEAR    | status IDLE/11: buffer, counters and outputs held at reset
//   CAPTURE  | status RUNNING: laps are written, reads allowed
//   HOLD     | status PAUSED: laps ignored, reads allowed
module lap_controller #(
    parameter int MIN_W = 8,
    parameter int SEC_W = 6,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int IDX_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       status,
    input  logic             lap,
    input  logic [MIN_W-1:0] cur_min,
    input  logic [SEC_W-1:0] cur_sec,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [MIN_W-1:0] rd_min,
    output logic [SEC_W-1:0] rd_sec,
    output logic [IDX_W-1:0] rd_idx,
    output logic [IDX_W-1:0] lap_count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    typedef enum logic [1:0] {
        MODE_CLEAR   = 2'b00,
        MODE_CAPTURE = 2'b01,
        MODE_HOLD    = 2'b10
    } mode_e;

    mode_e mode;

    logic [MIN_W-1:0] mem_min_q [DEPTH];
    logic [SEC_W-1:0] mem_sec_q [DEPTH];
    logic [IDX_W-1:0] mem_idx_q [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] lap_num_q, lap_num_d;
    logic [MIN_W-1:0] last_min_q, last_min_d;
    logic [SEC_W-1:0] last_sec_q, last_sec_d;
    logic             ovf_q, ovf_d;
    logic             rd_valid_q, rd_valid_d;
    logic [MIN_W-1:0] rd_min_q, rd_min_d;
    logic [SEC_W-1:0] rd_sec_q, rd_sec_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;

    logic             is_full, is_empty;
    logic             do_pop, do_write;
    logic [MIN_W-1:0] ent_min;
    logic [SEC_W-1:0] ent_sec;

    assign is_full  = (count_q == IDX_W'(DEPTH));
    assign is_empty = (count_q == '0);

    // Mode tracks status directly so a return to IDLE wins over a lap or
    // read arriving in the same cycle.
    always_comb begin
        mode = MODE_CLEAR;
        case (status)
            2'b01:   mode = MODE_CAPTURE;
            2'b10:   mode = MODE_HOLD;
            default: mode = MODE_CLEAR;
        endcase
    end

    always_comb begin
        ent_min = cur_min;
        ent_sec = cur_sec;
`ifdef LAP_DELTA_EN
        // Borrow case: the result is below 60, so SEC_W-bit modular math is exact.
        if (cur_sec >= last_sec_q) begin
            ent_sec = cur_sec - last_sec_q;
            ent_min = cur_min - last_min_q;
        end else begin
            ent_sec = cur_sec + SEC_W'(60) - last_sec_q;
            ent_min = cur_min - last_min_q - MIN_W'(1);
        end
`endif
    end

    // A pop frees the slot, so a same-cycle write is accepted even when full.
    assign do_pop   = (mode != MODE_CLEAR) && rd_req && !is_empty;
    assign do_write = (mode == MODE_CAPTURE) && lap && (!is_full || do_pop);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        lap_num_d  = lap_num_q;
        last_min_d = last_min_q;
        last_sec_d = last_sec_q;
        ovf_d      = ovf_q;
        rd_valid_d = 1'b0;
        rd_min_d   = rd_min_q;
        rd_sec_d   = rd_sec_q;
        rd_idx_d   = rd_idx_q;

        if (mode == MODE_CLEAR) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            lap_num_d  = '0;
            last_min_d = '0;
            last_sec_d = '0;
            ovf_d      = 1'b0;
            rd_min_d   = '0;
            rd_sec_d   = '0;
            rd_idx_d   = '0;
        end else begin
            if (do_pop) begin
                rptr_d     = rptr_q + PTR_W'(1);
                rd_valid_d = 1'b1;
                rd_min_d   = mem_min_q[rptr_q];
                rd_sec_d   = mem_sec_q[rptr_q];
                rd_idx_d   = mem_idx_q[rptr_q];
            end
            if (do_write) begin
                wptr_d     = wptr_q + PTR_W'(1);
                lap_num_d  = lap_num_q + IDX_W'(1);
                last_min_d = cur_min;
                last_sec_d = cur_sec;
            end else if (mode == MODE_CAPTURE && lap) begin
                ovf_d = 1'b1;
            end
            if (do_write && !do_pop)
                count_d = count_q + IDX_W'(1);
            else if (do_pop && !do_write)
                count_d = count_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            lap_num_q  <= '0;
            last_min_q <= '0;
            last_sec_q <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_min_q   <= '0;
            rd_sec_q   <= '0;
            rd_idx_q   <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            lap_num_q  <= lap_num_d;
            last_min_q <= last_min_d;
            last_sec_q <= last_sec_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_min_q   <= rd_min_d;
            rd_sec_q   <= rd_sec_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (rst_n && do_write) begin
            mem_min_q[wptr_q] <= ent_min;
            mem_sec_q[wptr_q] <= ent_sec;
            mem_idx_q[wptr_q] <= lap_num_q + IDX_W'(1);
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_min    = rd_min_q;
    assign rd_sec    = rd_sec_q;
    assign rd_idx    = rd_idx_q;
    assign lap_count = count_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign overflow  = ovf_q;

endmodule
